// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the 5-stage 16-bit CPU.
//   state_t         : hazard controller sequencing states
//   REG_W           : register-index width
//   DRAIN_DEPTH_DEF : default cycles for older instructions to retire after HLT
//   OP_*            : opcodes the hazard logic cares about
package cpu_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam int REG_W           = 4;
    localparam int DRAIN_DEPTH_DEF = 3;

    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/lu_detect.sv
// lu_detect: combinational load-use hazard detector.
//   rs_ID/rt_ID, uses_rs_ID/uses_rt_ID : sources read by the ID instruction
//   Rd_EX, RegWrite_EX, MemOp_EX, MemWrite_EX : EX instruction control
//   lu : EX holds a load whose result the ID instruction needs
module lu_detect
    import cpu_pkg::*;
(
    input  logic [REG_W-1:0] rs_ID,
    input  logic [REG_W-1:0] rt_ID,
    input  logic             uses_rs_ID,
    input  logic             uses_rt_ID,
    input  logic [REG_W-1:0] Rd_EX,
    input  logic             RegWrite_EX,
    input  logic             MemOp_EX,
    input  logic             MemWrite_EX,
    output logic             lu
);

    // R0 is hardwired zero, so a load into it never creates a dependency.
    assign lu = MemOp_EX & ~MemWrite_EX & RegWrite_EX & (Rd_EX != '0) &
                ((uses_rs_ID & (rs_ID == Rd_EX)) | (uses_rt_ID & (rt_ID == Rd_EX)));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller (stalls, flushes, wait states, halt).
//   Inputs : ID source fields/uses, hlt_ID, EX control, branch_taken_EX,
//            imem_ready, dmem_req_MEM, dmem_ready
//   Outputs: pc_en, en_* pipeline register enables, flush_IF_ID/flush_ID_EX,
//            hlt (halted), stall_cycles (saturating stall counter)
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int DRAIN_DEPTH = DRAIN_DEPTH_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs_ID,
    input  logic [REG_W-1:0] rt_ID,
    input  logic             uses_rs_ID,
    input  logic             uses_rt_ID,
    input  logic             hlt_ID,
    input  logic [REG_W-1:0] Rd_EX,
    input  logic             RegWrite_EX,
    input  logic             MemOp_EX,
    input  logic             MemWrite_EX,
    input  logic             branch_taken_EX,
    input  logic             imem_ready,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             en_IF_ID,
    output logic             en_ID_EX,
    output logic             en_EX_MEM,
    output logic             en_MEM_WB,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             hlt,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int CW = $clog2(DRAIN_DEPTH + 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          lu, freeze, stall;

    lu_detect u_lu (
        .rs_ID      (rs_ID),
        .rt_ID      (rt_ID),
        .uses_rs_ID (uses_rs_ID),
        .uses_rt_ID (uses_rt_ID),
        .Rd_EX      (Rd_EX),
        .RegWrite_EX(RegWrite_EX),
        .MemOp_EX   (MemOp_EX),
        .MemWrite_EX(MemWrite_EX),
        .lu         (lu)
    );

    assign freeze = dmem_req_MEM & ~dmem_ready;
    assign hlt    = (state == HALTED);
    assign stall  = ~(pc_en & en_IF_ID & en_ID_EX & en_EX_MEM & en_MEM_WB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // HLT is only accepted when nothing of higher priority claims the cycle;
    // a frozen cycle neither accepts it nor advances the drain.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == RUN && !freeze && !branch_taken_EX && !lu && hlt_ID) begin
            state_n = DRAIN;
            cnt_n   = CW'(DRAIN_DEPTH);
        end else if (state == DRAIN && !freeze) begin
            cnt_n   = cnt - CW'(1);
            state_n = (cnt == CW'(1)) ? HALTED : DRAIN;
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        en_IF_ID    = 1'b1;
        en_ID_EX    = 1'b1;
        en_EX_MEM   = 1'b1;
        en_MEM_WB   = 1'b1;
        flush_IF_ID = 1'b0;
        flush_ID_EX = 1'b0;
        if (rst || state == HALTED || freeze) begin
            pc_en     = 1'b0;
            en_IF_ID  = 1'b0;
            en_ID_EX  = 1'b0;
            en_EX_MEM = 1'b0;
            en_MEM_WB = 1'b0;
        end else if (state == DRAIN) begin
            pc_en       = 1'b0;
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
        end else if (branch_taken_EX) begin
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
        end else if (lu) begin
            pc_en       = 1'b0;
            en_IF_ID    = 1'b0;
            flush_ID_EX = 1'b1;
        end else if (hlt_ID) begin
            pc_en       = 1'b0;
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
        end else if (!imem_ready) begin
            pc_en       = 1'b0;
            flush_IF_ID = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (state != HALTED && stall && !(&stall_cycles))
            stall_cycles <= stall_cycles + CNT_W'(1);
    end

endmodule
